// File: rtl/exhaustive_vector_checker.sv
// -----------------------------------------------------------------------------
// exhaustive_vector_checker
//
// Sweeps every N_IN-bit vector into a combinational DUT in ascending order,
// holds each vector for SETTLE cycles, then samples for one cycle and compares
// the DUT outputs against the golden-model outputs. Accumulates mismatch and
// all-zero counts and captures the first failing vector.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   start            begin a sweep (honoured only in IDLE or DONE)
//   stim             vector driven to the DUT and the golden model
//   dut_out          DUT outputs
//   exp_out          golden-model outputs for the current stim
//   busy             high while sweeping (SETTLE or SAMPLE)
//   sample_strobe    high for the single SAMPLE cycle of each vector
//   done             high in DONE, held until restart or reset
//   pass             done with no mismatches
//   mismatch_cnt     vectors where dut_out != exp_out
//   zero_cnt         vectors where dut_out == 0
//   first_fail_valid at least one mismatch recorded
//   first_fail_vec   stim of the first mismatch
// -----------------------------------------------------------------------------
module exhaustive_vector_checker #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] exp_out,
    output logic             busy,
    output logic             sample_strobe,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    mismatch_cnt,
    output logic [N_IN:0]    zero_cnt,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (start) state_next = S_SETTLE;
            S_SETTLE: if (cnt == CNT_LAST) state_next = S_SAMPLE;
            S_SAMPLE: state_next = (stim == STIM_LAST) ? S_DONE : S_SETTLE;
            S_DONE:   if (start) state_next = S_SETTLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            stim             <= '0;
            busy             <= 1'b0;
            sample_strobe    <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            zero_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            state         <= state_next;
            // Status flags are registered from the next state so they line up
            // with the state they describe.
            busy          <= (state_next == S_SETTLE) || (state_next == S_SAMPLE);
            sample_strobe <= (state_next == S_SAMPLE);

            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        stim             <= '0;
                        cnt              <= '0;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        mismatch_cnt     <= '0;
                        zero_cnt         <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end else if (state == S_DONE) begin
                        // Counters are frozen here, so pass reflects the final tally.
                        done <= 1'b1;
                        pass <= (mismatch_cnt == '0);
                    end
                end
                S_SETTLE: cnt <= cnt + 1'b1;
                S_SAMPLE: begin
                    if (dut_out != exp_out) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= stim;
                        end
                    end
                    if (dut_out == '0) zero_cnt <= zero_cnt + 1'b1;
                    // The last vector stays on stim through DONE; no wrap.
                    if (stim != STIM_LAST) begin
                        stim <= stim + 1'b1;
                        cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// -----------------------------------------------------------------------------
// tb_exhaustive_vector_checker
//
// Two checker instances: A (N_IN=3, SETTLE=4) and B (N_IN=1, SETTLE=1). The
// DUT outputs are the golden function XOR a per-vector error mask; expected
// results are derived from the masks by counting, and the cycle-by-cycle
// behaviour from the sweep's arithmetic timeline.
// -----------------------------------------------------------------------------
module tb_exhaustive_vector_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start;
    int   sel;
    int   asserts = 0;
    int   failures = 0;

    logic [1:0] err_a [8];
    logic [1:0] err_b [2];

    // Instance A
    logic [2:0] a_stim, a_ffvec;
    logic [1:0] a_dut, a_exp;
    logic [3:0] a_mm, a_zero;
    logic       a_busy, a_strobe, a_done, a_pass, a_ffv, a_start;

    // Instance B
    logic [0:0] b_stim, b_ffvec;
    logic [1:0] b_dut, b_exp;
    logic [1:0] b_mm, b_zero;
    logic       b_busy, b_strobe, b_done, b_pass, b_ffv, b_start;

    function automatic logic [1:0] gold_a(input logic [2:0] v);
        return {v[2] & v[1], v[1] ^ v[0]};
    endfunction

    function automatic logic [1:0] gold_b(input logic [0:0] v);
        return {1'b0, v[0]};
    endfunction

    always_comb begin
        a_exp = gold_a(a_stim);
        a_dut = a_exp ^ err_a[a_stim];
        b_exp = gold_b(b_stim);
        b_dut = b_exp ^ err_b[b_stim];
    end

    assign a_start = start && (sel == 0);
    assign b_start = start && (sel == 1);

    exhaustive_vector_checker #(.N_IN(3), .N_OUT(2), .SETTLE(4)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .stim(a_stim),
        .dut_out(a_dut), .exp_out(a_exp), .busy(a_busy),
        .sample_strobe(a_strobe), .done(a_done), .pass(a_pass),
        .mismatch_cnt(a_mm), .zero_cnt(a_zero),
        .first_fail_valid(a_ffv), .first_fail_vec(a_ffvec)
    );

    exhaustive_vector_checker #(.N_IN(1), .N_OUT(2), .SETTLE(1)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .stim(b_stim),
        .dut_out(b_dut), .exp_out(b_exp), .busy(b_busy),
        .sample_strobe(b_strobe), .done(b_done), .pass(b_pass),
        .mismatch_cnt(b_mm), .zero_cnt(b_zero),
        .first_fail_valid(b_ffv), .first_fail_vec(b_ffvec)
    );

    // Observation view of the currently selected instance.
    logic [15:0] o_stim, o_ffvec;
    int          o_mm, o_zero;
    logic        o_busy, o_strobe, o_done, o_pass, o_ffv;

    always_comb begin
        if (sel == 0) begin
            o_stim = 16'(a_stim);  o_ffvec = 16'(a_ffvec);
            o_mm = int'(a_mm);     o_zero = int'(a_zero);
            o_busy = a_busy; o_strobe = a_strobe; o_done = a_done;
            o_pass = a_pass; o_ffv = a_ffv;
        end else begin
            o_stim = 16'(b_stim);  o_ffvec = 16'(b_ffvec);
            o_mm = int'(b_mm);     o_zero = int'(b_zero);
            o_busy = b_busy; o_strobe = b_strobe; o_done = b_done;
            o_pass = b_pass; o_ffv = b_ffv;
        end
    end

    // One full sweep on instance `which`, checked every cycle against the
    // timeline: vector k occupies cycles [k*per, k*per+per), its sample cycle
    // is the last of those, and done appears one cycle after the sweep ends.
    task automatic run_sweep(input int which, input int n_in, input int settle,
                             input bit poke, input string name);
        int nvec = 1 << n_in;
        int per  = settle + 1;
        int exp_mm = 0, exp_zero = 0, exp_ff = -1;
        int done_edge = -1;
        int strobes = 0;
        logic [18:0] got_t, exp_t;

        for (int v = 0; v < nvec; v++) begin
            logic [1:0] e, o;
            e = (which == 0) ? err_a[v] : err_b[v];
            o = ((which == 0) ? gold_a(3'(v)) : gold_b(1'(v))) ^ e;
            if (e != 2'b00) begin
                exp_mm++;
                if (exp_ff < 0) exp_ff = v;
            end
            if (o == 2'b00) exp_zero++;
        end

        sel = which;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        asserts++;
        if (o_mm !== 0 || o_zero !== 0 || o_ffv !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0) begin
            failures++;
            $display("FAIL %s start_clear: mm=%0d zero=%0d ffv=%b done=%b pass=%b, want all 0",
                     name, o_mm, o_zero, o_ffv, o_done, o_pass);
        end

        for (int n = 0; n <= nvec * per + 3; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (poke && n == 12) start = 1'b1;
            if (poke && n == 13) start = 1'b0;
            if (n < nvec * per)
                exp_t = {16'(n / per), 1'b1, (n % per) == settle, 1'b0};
            else
                exp_t = {16'(nvec - 1), 1'b0, 1'b0, n >= nvec * per + 1};
            got_t = {o_stim, o_busy, o_strobe, o_done};
            asserts++;
            if (got_t !== exp_t) begin
                failures++;
                $display("FAIL %s cycle %0d: stim/busy/strobe/done = %0d/%b/%b/%b, want %0d/%b/%b/%b",
                         name, n, got_t[18:3], got_t[2], got_t[1], got_t[0],
                         exp_t[18:3], exp_t[2], exp_t[1], exp_t[0]);
            end
            if (o_strobe) strobes++;
            if (o_done && done_edge < 0) done_edge = n;
        end

        asserts++;
        if (done_edge !== nvec * per + 1) begin
            failures++;
            $display("FAIL %s done_edge: got E0+%0d, want E0+%0d", name, done_edge, nvec * per + 1);
        end
        asserts++;
        if (strobes !== nvec) begin
            failures++;
            $display("FAIL %s strobe_count: got %0d, want %0d", name, strobes, nvec);
        end
        asserts++;
        if (o_mm !== exp_mm || o_zero !== exp_zero) begin
            failures++;
            $display("FAIL %s counts: mm=%0d zero=%0d, want mm=%0d zero=%0d",
                     name, o_mm, o_zero, exp_mm, exp_zero);
        end
        asserts++;
        if (o_pass !== (exp_mm == 0) || o_ffv !== (exp_ff >= 0)) begin
            failures++;
            $display("FAIL %s pass/ffv: pass=%b ffv=%b, want pass=%b ffv=%b",
                     name, o_pass, o_ffv, exp_mm == 0, exp_ff >= 0);
        end
        if (exp_ff >= 0) begin
            asserts++;
            if (o_ffvec !== 16'(exp_ff)) begin
                failures++;
                $display("FAIL %s first_fail_vec: got %0d, want %0d", name, o_ffvec, exp_ff);
            end
        end
    endtask

    task automatic check_cleared(input string name);
        asserts++;
        if ({a_stim, a_busy, a_strobe, a_done, a_pass, a_mm, a_zero, a_ffv, a_ffvec} !== '0) begin
            failures++;
            $display("FAIL %s inst_a: stim=%0d busy=%b strobe=%b done=%b pass=%b mm=%0d zero=%0d ffv=%b ffvec=%0d, want all 0",
                     name, a_stim, a_busy, a_strobe, a_done, a_pass, a_mm, a_zero, a_ffv, a_ffvec);
        end
        asserts++;
        if ({b_stim, b_busy, b_strobe, b_done, b_pass, b_mm, b_zero, b_ffv, b_ffvec} !== '0) begin
            failures++;
            $display("FAIL %s inst_b: stim=%0d busy=%b strobe=%b done=%b pass=%b mm=%0d zero=%0d ffv=%b ffvec=%0d, want all 0",
                     name, b_stim, b_busy, b_strobe, b_done, b_pass, b_mm, b_zero, b_ffv, b_ffvec);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;
    endtask

    task automatic test_correct();
        for (int v = 0; v < 8; v++) err_a[v] = 2'b00;
        run_sweep(0, 3, 4, 1'b0, "correct");
    endtask

    task automatic test_tied_zero();
        for (int v = 0; v < 8; v++) err_a[v] = gold_a(3'(v));
        run_sweep(0, 3, 4, 1'b0, "tied_zero");
    endtask

    task automatic test_mid_reset();
        sel = 0;
        for (int v = 0; v < 8; v++) err_a[v] = 2'($urandom_range(0, 3));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Vector 5 occupies cycles 25..29; cycle 26 is mid-settle.
        repeat (26) @(posedge clk);
        #1;
        asserts++;
        if (a_stim !== 3'd5 || a_busy !== 1'b1 || a_strobe !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset pre: stim=%0d busy=%b strobe=%b, want 5/1/0", a_stim, a_busy, a_strobe);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_cleared("mid_reset");
        for (int v = 0; v < 8; v++) err_a[v] = 2'b00;
        run_sweep(0, 3, 4, 1'b0, "after_reset");
    endtask

    task automatic test_start_while_busy();
        for (int v = 0; v < 8; v++) err_a[v] = (v == 6) ? 2'b10 : 2'b00;
        run_sweep(0, 3, 4, 1'b1, "start_busy");
    endtask

    task automatic test_restart_after_fail();
        for (int v = 0; v < 8; v++) err_a[v] = gold_a(3'(v));
        run_sweep(0, 3, 4, 1'b0, "fail_run");
        for (int v = 0; v < 8; v++) err_a[v] = 2'b00;
        run_sweep(0, 3, 4, 1'b0, "restart");
    endtask

    task automatic test_random_a();
        for (int it = 0; it < 4; it++) begin
            for (int v = 0; v < 8; v++)
                err_a[v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_sweep(0, 3, 4, 1'b0, "random_a");
        end
    endtask

    task automatic test_small();
        for (int it = 0; it < 4; it++) begin
            for (int v = 0; v < 2; v++) err_b[v] = 2'($urandom_range(0, 3));
            run_sweep(1, 1, 1, 1'b0, "small");
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sel   = 0;
        for (int v = 0; v < 8; v++) err_a[v] = 2'b00;
        for (int v = 0; v < 2; v++) err_b[v] = 2'b00;

        test_reset();
        test_correct();
        test_tied_zero();
        test_mid_reset();
        test_start_while_busy();
        test_restart_after_fail();
        test_random_a();
        test_small();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/exhaustive_vector_checker.md
Name: exhaustive_vector_checker

Overview:
- Synthesizable, self-checking successor to our hand-written exhaustive combinational benches.
- On start, sweeps every N_IN-bit input vector into a combinational DUT in ascending order. Waits a programmable settle time, then compares DUT outputs against a golden-model output.
- Accumulates mismatch and all-outputs-zero counts and captures the first failing vector.
- Sits between the stimulus/golden model and the DUT, in bench tops or on-board lab test harnesses.

Parameters:
- N_IN, 3, number of DUT inputs; sweep covers 2^N_IN vectors; legal range 1..16.
- N_OUT, 2, number of DUT outputs compared.
- SETTLE, 20, clock cycles each vector is held before sampling; minimum 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin sweep; sampled only in IDLE or DONE
- stim  output  N_IN  vector driven to DUT and golden model
- dut_out  input  N_OUT  DUT outputs
- exp_out  input  N_OUT  golden-model outputs for current stim
- busy  output  1  high while sweeping (SETTLE or SAMPLE state)
- sample_strobe  output  1  high for the one SAMPLE cycle of each vector
- done  output  1  high in DONE, held until restart or reset
- pass  output  1  done and mismatch_cnt==0
- mismatch_cnt  output  N_IN+1  vectors where dut_out!=exp_out
- zero_cnt  output  N_IN+1  vectors where dut_out==0 (all outputs zero)
- first_fail_valid  output  1  at least one mismatch recorded
- first_fail_vec  output  N_IN  stim of first mismatch

Behaviour:
- Reset (synchronous, active-high): state=IDLE; stim=0, busy=0, sample_strobe=0, done=0, pass=0, mismatch_cnt=0, zero_cnt=0, first_fail_valid=0, first_fail_vec=0; settle counter=0.
- Reset asserted mid-sweep aborts the sweep on that edge; all results are discarded.
- All outputs are registered. stim changes only on the edge entering SETTLE.
- State IDLE:
  - start=1 -> SETTLE, with stim=0, settle cnt=0.
  - Counters, first_fail_* and pass are cleared on the same edge.
- State SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE-1 -> SAMPLE, so stim is held exactly SETTLE cycles before sampling.
- State SAMPLE (sample_strobe=1):
  - If dut_out!=exp_out: mismatch_cnt+1. If first_fail_valid==0, capture first_fail_vec=stim and set first_fail_valid=1.
  - If dut_out==0: zero_cnt+1. This is independent of the mismatch check.
  - If stim=={N_IN{1'b1}} -> DONE. Otherwise stim+1, cnt=0, -> SETTLE.
  - stim never wraps during a sweep.
- State DONE:
  - done=1; pass=(mismatch_cnt==0); stim holds the last vector; counters are frozen.
  - start=1 restarts exactly as from IDLE, clearing results, and done drops on that edge.
- start while busy is ignored, with no effect on stim or counters.
- Counter width N_IN+1 holds the maximum 2^N_IN without saturation.
- Timing: start sampled high at edge E0.
  - Vector k is sampled at edge E0 + k*(SETTLE+1) + SETTLE + 1.
  - done rises at edge E0 + 2^N_IN*(SETTLE+1) + 1.
- dut_out/exp_out are only sampled in SAMPLE; their values in other states are don't-care.

Test Plan:
- N_IN=3, N_OUT=2, SETTLE=4; exp_out and dut_out both driven as {a&b, b^c} of stim.
  - Expect done at E0+41.
  - mismatch_cnt=0, pass=1, first_fail_valid=0.
  - zero_cnt=3 (stim=0,3,4).
- Same config, dut_out tied to 0, exp_out={a&b, b^c}.
  - Expect mismatch_cnt=5, zero_cnt=8.
  - first_fail_vec=1, first_fail_valid=1, pass=0.
  - sample_strobe pulses exactly 8 times, each 5 cycles apart.
- Assert reset for one cycle while stim=5 mid-settle.
  - Next cycle: state IDLE, stim=0, all counters 0, busy=0, done=0.
  - A subsequent start completes a full clean sweep.
- Pulse start at stim=2 while busy.
  - Sweep unaffected: stim still steps 2->3 at its normal edge; done timing unchanged.
- After a failing run reaches DONE, pulse start with a correct dut_out.
  - mismatch_cnt, zero_cnt and first_fail_valid clear on the start edge; done drops.
  - Final pass=1.
- N_IN=1, SETTLE=1.
  - stim sequence 0,0,1,1 (2 cycles per vector).
  - done at E0+5; mismatch_cnt width 2; counts correct for both vectors.
